seg7_scan_driver: RTL

- Downstream stage of the traffic-light countdown controller.
- Takes four BCD digits and time-multiplexes them onto one shared 7-segment bus with per-digit anode enables.
- Replaces four parallel static decoders with one scanned display.
- Adds a tear-free double buffer, leading-zero blanking, an inter-digit guard (anti-ghosting) and a frame tick.

---
 rtl/seg7_scan_driver_pkg.sv | 48 ++++
 rtl/seg7_scan_driver_if.sv | 44 ++++
 rtl/seg7_scan_driver_bcd_decode.sv | 30 +++
 rtl/seg7_scan_driver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared constants, types and helpers for the scanned 7-segment driver
//
// Package seg7_pkg
//   NUM_DIGITS     : number of scanned digits (4)
//   digit_idx_t    : 2-bit scan index type
//   SEG_0..SEG_9   : active-high segment patterns, bit0=a ... bit6=g
//   SEG_DASH       : pattern shown for non-BCD codes (g only)
//   SEG_OFF        : all segments dark (active-high form)
//   frame_buf_t    : one frame of display content (4 BCD digits + 4 decimal points)
//   lz_blank_mask  : which digits are leading zeros of a 4-digit value
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    //                                 gfedcba
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
    } frame_buf_t;

    // Bit i set when digit i is a leading zero: it and every more
    // significant digit are zero. Digit 0 is never a leading zero so an
    // all-zero value still shows a single "0".
    function automatic logic [3:0] lz_blank_mask(input logic [15:0] d);
        logic [3:0] m;
        m[3] = (d[15:12] == 4'd0);
        m[2] = m[3] && (d[11:8] == 4'd0);
        m[1] = m[2] && (d[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - bundle of data-in and display-out signals for the scan driver
//
// Interface seg7_scan_driver_if
//   load        : one-cycle strobe capturing digits_in/dp_in into the shadow buffer
//   digits_in   : four BCD digits, [3:0]=digit0 (LSD) .. [15:12]=digit3 (MSD)
//   dp_in       : decimal-point request per digit
//   lz_en       : leading-zero blanking enable (level)
//   blink_mask  : per-digit blink enable (only with SEG7_SCAN_BLINK_EN)
//   seg         : shared segment bus, seg[0]=a .. seg[6]=g
//   dp          : decimal point of the active digit
//   an          : per-digit anode enables
//   frame_tick  : one-cycle pulse when the scan wraps digit 3 -> digit 0
// Modports: master = data producer / display observer, slave = the driver.
interface seg7_scan_driver_if;

    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_en;
`ifdef SEG7_SCAN_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    modport master (
        output load, digits_in, dp_in, lz_en,
`ifdef SEG7_SCAN_BLINK_EN
        output blink_mask,
`endif
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  load, digits_in, dp_in, lz_en,
`ifdef SEG7_SCAN_BLINK_EN
        input  blink_mask,
`endif
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/seg7_scan_driver_bcd_decode.sv
// rtl/seg7_scan_driver_bcd_decode.sv - combinational BCD to active-high 7-segment decoder
//
// Module seg7_bcd_decode
//   bcd_i : 4-bit digit code
//   seg_o : active-high segment pattern (bit0=a .. bit6=g); codes 10-15 give a dash
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed four-digit 7-segment driver with double buffer
//
// Module seg7_scan_driver
//   Parameters : SCAN_DIV (cycles per digit slot, >= GUARD+2), GUARD (dark cycles
//                at slot start), SEG_ACTIVE_LOW, AN_ACTIVE_LOW, and BLINK_FRAMES
//                when SEG7_SCAN_BLINK_EN is defined.
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   bus        : seg7_scan_driver_if.slave (load/digits_in/dp_in/lz_en in,
//                seg/dp/an/frame_tick out, blink_mask in with SEG7_SCAN_BLINK_EN)
// Optional feature macro: SEG7_SCAN_BLINK_EN (frame-rate blinking of masked digits).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
`ifdef SEG7_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int            CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    // Pin levels for "dark" so reset and blanking need no polarity logic.
    localparam logic [6:0] SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic       DP_DARK  = SEG_ACTIVE_LOW;
    localparam logic [3:0] AN_IDLE  = AN_ACTIVE_LOW ? 4'b1111 : 4'b0000;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    frame_buf_t       shadow_q, shadow_d;
    frame_buf_t       disp_q, disp_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             tick_q, tick_d;

    logic             slot_end;
    logic             wrap;
    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;
    logic [3:0]       blank_mask;
    logic             in_guard;
    logic             hide_seg;
    logic             hide_dp;
    logic [6:0]       lit_seg;
    logic             lit_dp;
    logic [3:0]       an_onehot;
    logic             blink_hide;

    seg7_bcd_decode u_decode (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

`ifdef SEG7_SCAN_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0] fcnt_q, fcnt_d;
    logic            blink_off_q, blink_off_d;

    // The phase flips on the wrap edge itself so a whole frame is either
    // on or off; it never changes in the middle of a scan.
    always_comb begin
        fcnt_d      = fcnt_q;
        blink_off_d = blink_off_q;
        if (wrap) begin
            if (fcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                fcnt_d      = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                fcnt_d = fcnt_q + BF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q      <= '0;
            blink_off_q <= 1'b0;
        end else begin
            fcnt_q      <= fcnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign blink_hide = blink_off_q & bus.blink_mask[idx_q];
`else
    assign blink_hide = 1'b0;
`endif

    always_comb begin
        slot_end  = (cnt_q == CNT_MAX);
        wrap      = slot_end && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = slot_end ? idx_q + digit_idx_t'(1) : idx_q;

        // Double buffer: display only ever changes on the wrap edge, so a
        // load anywhere in a frame cannot mix old and new digits. A load on
        // the wrap edge lands in shadow while the previous shadow is shown.
        shadow_d  = shadow_q;
        if (bus.load) begin
            shadow_d.digits = bus.digits_in;
            shadow_d.dp     = bus.dp_in;
        end
        disp_d    = wrap ? shadow_q : disp_q;
        tick_d    = wrap;

        cur_digit  = disp_q.digits[{idx_q, 2'b00} +: 4];
        blank_mask = lz_blank_mask(disp_q.digits);

        // Leading-zero blanking darkens segments only; the digit's dp and
        // anode timing are unaffected. Blinking darkens both.
        hide_seg  = (bus.lz_en & blank_mask[idx_q]) | blink_hide;
        hide_dp   = blink_hide;
        lit_seg   = hide_seg ? SEG_OFF : dec_seg;
        lit_dp    = hide_dp ? 1'b0 : disp_q.dp[idx_q];

        // During the guard window the segment bus already carries the new
        // digit while every anode is off, so the previous digit never
        // flashes the new pattern.
        in_guard  = int'(cnt_q) < GUARD;
        an_onehot = in_guard ? 4'b0000 : (4'b0001 << idx_q);

        seg_d     = SEG_ACTIVE_LOW ? ~lit_seg : lit_seg;
        dp_d      = SEG_ACTIVE_LOW ? ~lit_dp : lit_dp;
        an_d      = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            seg_q    <= SEG_DARK;
            dp_q     <= DP_DARK;
            an_q     <= AN_IDLE;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;

endmodule
